// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM stage with byte/half/word data memory, sticky misaligned flag and debug read port
module mem_stage #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 7,
  parameter int NB_REG  = 5,
  parameter int NB_PC   = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_MEM_mem_read,
  input  logic               i_MEM_mem_write,
  input  logic [1:0]         i_MEM_bhw,
  input  logic               i_MEM_signed,
  input  logic [NB_DATA-1:0] i_MEM_alu_result,
  input  logic [NB_DATA-1:0] i_MEM_write_data,
  input  logic               i_MEM_reg_write,
  input  logic               i_MEM_mem_to_reg,
  input  logic               i_MEM_r31_ctrl,
  input  logic [NB_REG-1:0]  i_MEM_selected_reg,
  input  logic [NB_PC-1:0]   i_MEM_pc,
  input  logic [NB_ADDR-1:0] i_du_addr,
  output logic [NB_DATA-1:0] o_MEM_mem_data,
  output logic [NB_DATA-1:0] o_MEM_alu_result,
  output logic               o_MEM_reg_write,
  output logic               o_MEM_mem_to_reg,
  output logic               o_MEM_r31_ctrl,
  output logic [NB_REG-1:0]  o_MEM_selected_reg,
  output logic [NB_PC-1:0]   o_MEM_pc,
  output logic               o_MEM_misaligned,
  output logic [NB_DATA-1:0] o_du_data
);
  logic [NB_DATA-1:0] mem [2**NB_ADDR];
  logic [NB_ADDR-1:0] idx;
  logic [1:0]         lane;
  logic               is_byte, is_half, mis;
  logic [3:0]         be;
  logic [31:0]        wdata, rd_word;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic [31:0]        ext;
  assign idx     = i_MEM_alu_result[NB_ADDR+1:2];
  assign lane    = i_MEM_alu_result[1:0];
  assign is_byte = i_MEM_bhw == 2'b00;
  assign is_half = i_MEM_bhw == 2'b01;
  assign mis     = is_half ? lane[0] : !is_byte && lane != 2'b00;
  assign be      = is_byte ? 4'b0001 << lane : is_half ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata   = is_byte ? {4{i_MEM_write_data[7:0]}} : is_half ? {2{i_MEM_write_data[15:0]}} : i_MEM_write_data[31:0];
  assign rd_word = mem[idx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
  assign ext     = is_byte ? {{24{i_MEM_signed & rd_byte[7]}}, rd_byte} :
                   is_half ? {{16{i_MEM_signed & rd_half[15]}}, rd_half} : rd_word;
  assign o_MEM_mem_data     = (i_MEM_mem_read && !mis) ? ext : '0;
  assign o_MEM_alu_result   = i_MEM_alu_result;
  assign o_MEM_reg_write    = i_MEM_reg_write;
  assign o_MEM_mem_to_reg   = i_MEM_mem_to_reg;
  assign o_MEM_r31_ctrl     = i_MEM_r31_ctrl;
  assign o_MEM_selected_reg = i_MEM_selected_reg;
  assign o_MEM_pc           = i_MEM_pc;
  assign o_du_data          = mem[i_du_addr];
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 2**NB_ADDR; i++) mem[i] <= '0;
      o_MEM_misaligned <= 1'b0;
    end else if (i_enable) begin
      if ((i_MEM_mem_read || i_MEM_mem_write) && mis) o_MEM_misaligned <= 1'b1;
      if (i_MEM_mem_write && !mis)
        for (int b = 0; b < 4; b++)
          if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage
module tb_mem_stage;
  logic        i_clock = 1'b0, i_reset = 1'b1, i_enable = 1'b1;
  logic        i_MEM_mem_read, i_MEM_mem_write, i_MEM_signed;
  logic [1:0]  i_MEM_bhw;
  logic [31:0] i_MEM_alu_result, i_MEM_write_data;
  logic        i_MEM_reg_write, i_MEM_mem_to_reg, i_MEM_r31_ctrl;
  logic [4:0]  i_MEM_selected_reg;
  logic [31:0] i_MEM_pc;
  logic [6:0]  i_du_addr;
  logic [31:0] o_MEM_mem_data, o_MEM_alu_result, o_MEM_pc, o_du_data;
  logic        o_MEM_reg_write, o_MEM_mem_to_reg, o_MEM_r31_ctrl, o_MEM_misaligned;
  logic [4:0]  o_MEM_selected_reg;
  int passed = 0, total = 0;
  mem_stage dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable),
    .i_MEM_mem_read(i_MEM_mem_read), .i_MEM_mem_write(i_MEM_mem_write),
    .i_MEM_bhw(i_MEM_bhw), .i_MEM_signed(i_MEM_signed),
    .i_MEM_alu_result(i_MEM_alu_result), .i_MEM_write_data(i_MEM_write_data),
    .i_MEM_reg_write(i_MEM_reg_write), .i_MEM_mem_to_reg(i_MEM_mem_to_reg),
    .i_MEM_r31_ctrl(i_MEM_r31_ctrl), .i_MEM_selected_reg(i_MEM_selected_reg),
    .i_MEM_pc(i_MEM_pc), .i_du_addr(i_du_addr),
    .o_MEM_mem_data(o_MEM_mem_data), .o_MEM_alu_result(o_MEM_alu_result),
    .o_MEM_reg_write(o_MEM_reg_write), .o_MEM_mem_to_reg(o_MEM_mem_to_reg),
    .o_MEM_r31_ctrl(o_MEM_r31_ctrl), .o_MEM_selected_reg(o_MEM_selected_reg),
    .o_MEM_pc(o_MEM_pc), .o_MEM_misaligned(o_MEM_misaligned), .o_du_data(o_du_data)
  );
  always #5 i_clock = ~i_clock;
  task automatic set_acc(input logic rd, input logic wr, input logic [1:0] bhw,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] data);
    i_MEM_mem_read = rd;
    i_MEM_mem_write = wr;
    i_MEM_bhw = bhw;
    i_MEM_signed = sgn;
    i_MEM_alu_result = addr;
    i_MEM_write_data = data;
  endtask
  task automatic store(input logic [1:0] bhw, input logic [31:0] addr, input logic [31:0] data);
    @(negedge i_clock);
    set_acc(1'b0, 1'b1, bhw, 1'b0, addr, data);
    @(posedge i_clock);
    #1 set_acc(1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
  endtask
  task automatic load(input logic [1:0] bhw, input logic sgn, input logic [31:0] addr);
    set_acc(1'b1, 1'b0, bhw, sgn, addr, 32'h0);
    #1;
  endtask
  task automatic test_reset;
    set_acc(1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    i_MEM_reg_write = 0; i_MEM_mem_to_reg = 0; i_MEM_r31_ctrl = 0;
    i_MEM_selected_reg = 0; i_MEM_pc = 0; i_du_addr = 0;
    i_reset = 1'b1;
    repeat (2) @(negedge i_clock);
    i_reset = 1'b0;
    foreach (i_du_addr[k]) ;
    i_du_addr = 7'd0; #1;
    total++; if (o_du_data !== 32'h0) $display("FAIL reset_du0 got %h exp %h", o_du_data, 32'h0); else passed++;
    i_du_addr = 7'd64; #1;
    total++; if (o_du_data !== 32'h0) $display("FAIL reset_du64 got %h exp %h", o_du_data, 32'h0); else passed++;
    i_du_addr = 7'd127; #1;
    total++; if (o_du_data !== 32'h0) $display("FAIL reset_du127 got %h exp %h", o_du_data, 32'h0); else passed++;
    total++; if (o_MEM_misaligned !== 1'b0) $display("FAIL reset_flag got %b exp 0", o_MEM_misaligned); else passed++;
    load(2'b11, 1'b0, 32'h0);
    total++; if (o_MEM_mem_data !== 32'h0) $display("FAIL reset_load got %h exp %h", o_MEM_mem_data, 32'h0); else passed++;
  endtask
  task automatic test_word;
    i_du_addr = 7'd4;
    @(negedge i_clock);
    set_acc(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF);
    #1;
    total++; if (o_du_data !== 32'h0) $display("FAIL word_pre_edge got %h exp %h", o_du_data, 32'h0); else passed++;
    @(posedge i_clock);
    #1 set_acc(1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    load(2'b11, 1'b0, 32'h10);
    total++; if (o_MEM_mem_data !== 32'hDEADBEEF) $display("FAIL word_load got %h exp %h", o_MEM_mem_data, 32'hDEADBEEF); else passed++;
    total++; if (o_du_data !== 32'hDEADBEEF) $display("FAIL word_du got %h exp %h", o_du_data, 32'hDEADBEEF); else passed++;
    i_MEM_mem_read = 1'b0; #1;
    total++; if (o_MEM_mem_data !== 32'h0) $display("FAIL no_read_zero got %h exp %h", o_MEM_mem_data, 32'h0); else passed++;
  endtask
  task automatic test_byte;
    store(2'b00, 32'h21, 32'hFFFFFF80);
    load(2'b00, 1'b1, 32'h21);
    total++; if (o_MEM_mem_data !== 32'hFFFFFF80) $display("FAIL byte_signed got %h exp %h", o_MEM_mem_data, 32'hFFFFFF80); else passed++;
    load(2'b00, 1'b0, 32'h21);
    total++; if (o_MEM_mem_data !== 32'h00000080) $display("FAIL byte_unsigned got %h exp %h", o_MEM_mem_data, 32'h00000080); else passed++;
    load(2'b11, 1'b0, 32'h20);
    total++; if (o_MEM_mem_data !== 32'h00008000) $display("FAIL byte_word got %h exp %h", o_MEM_mem_data, 32'h00008000); else passed++;
    load(2'b00, 1'b1, 32'h13);
    total++; if (o_MEM_mem_data !== 32'hFFFFFFDE) $display("FAIL byte_lane3 got %h exp %h", o_MEM_mem_data, 32'hFFFFFFDE); else passed++;
  endtask
  task automatic test_half;
    store(2'b11, 32'h30, 32'hAAAAAAAA);
    store(2'b01, 32'h32, 32'h00001234);
    load(2'b11, 1'b0, 32'h30);
    total++; if (o_MEM_mem_data !== 32'h1234AAAA) $display("FAIL half_word got %h exp %h", o_MEM_mem_data, 32'h1234AAAA); else passed++;
    load(2'b01, 1'b1, 32'h32);
    total++; if (o_MEM_mem_data !== 32'h00001234) $display("FAIL half_hi got %h exp %h", o_MEM_mem_data, 32'h00001234); else passed++;
    load(2'b01, 1'b1, 32'h30);
    total++; if (o_MEM_mem_data !== 32'hFFFFAAAA) $display("FAIL half_lo_signed got %h exp %h", o_MEM_mem_data, 32'hFFFFAAAA); else passed++;
    load(2'b10, 1'b0, 32'h30);
    total++; if (o_MEM_mem_data !== 32'h1234AAAA) $display("FAIL bhw10_word got %h exp %h", o_MEM_mem_data, 32'h1234AAAA); else passed++;
  endtask
  task automatic test_enable;
    i_du_addr = 7'd2;
    i_enable = 1'b0;
    store(2'b11, 32'h08, 32'h55);
    total++; if (o_du_data !== 32'h0) $display("FAIL enable_off got %h exp %h", o_du_data, 32'h0); else passed++;
    i_enable = 1'b1;
    store(2'b11, 32'h208, 32'h55);
    total++; if (o_du_data !== 32'h55) $display("FAIL alias_store got %h exp %h", o_du_data, 32'h55); else passed++;
  endtask
  task automatic test_misaligned;
    i_du_addr = 7'd16;
    i_enable = 1'b0;
    store(2'b11, 32'h41, 32'hCAFEF00D);
    total++; if (o_MEM_misaligned !== 1'b0) $display("FAIL mis_disabled got %b exp 0", o_MEM_misaligned); else passed++;
    i_enable = 1'b1;
    load(2'b01, 1'b0, 32'h31);
    total++; if (o_MEM_mem_data !== 32'h0) $display("FAIL mis_load_zero got %h exp %h", o_MEM_mem_data, 32'h0); else passed++;
    total++; if (o_MEM_misaligned !== 1'b0) $display("FAIL mis_pre_edge got %b exp 0", o_MEM_misaligned); else passed++;
    i_MEM_mem_read = 1'b0;
    store(2'b11, 32'h41, 32'hCAFEF00D);
    total++; if (o_du_data !== 32'h0) $display("FAIL mis_store_suppressed got %h exp %h", o_du_data, 32'h0); else passed++;
    total++; if (o_MEM_misaligned !== 1'b1) $display("FAIL mis_flag_set got %b exp 1", o_MEM_misaligned); else passed++;
    store(2'b11, 32'h40, 32'h11223344);
    load(2'b11, 1'b0, 32'h40);
    total++; if (o_MEM_mem_data !== 32'h11223344) $display("FAIL mis_valid_after got %h exp %h", o_MEM_mem_data, 32'h11223344); else passed++;
    @(posedge i_clock); #1;
    total++; if (o_MEM_misaligned !== 1'b1) $display("FAIL mis_sticky got %b exp 1", o_MEM_misaligned); else passed++;
  endtask
  task automatic test_rw_same;
    @(negedge i_clock);
    set_acc(1'b1, 1'b1, 2'b11, 1'b0, 32'h40, 32'h99887766);
    #1;
    total++; if (o_MEM_mem_data !== 32'h11223344) $display("FAIL rw_old_data got %h exp %h", o_MEM_mem_data, 32'h11223344); else passed++;
    @(posedge i_clock); #1;
    total++; if (o_MEM_mem_data !== 32'h99887766) $display("FAIL rw_new_data got %h exp %h", o_MEM_mem_data, 32'h99887766); else passed++;
    set_acc(1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
  endtask
  task automatic test_passthrough;
    i_MEM_alu_result = 32'h89ABCDEF; i_MEM_reg_write = 1; i_MEM_mem_to_reg = 1;
    i_MEM_r31_ctrl = 1; i_MEM_selected_reg = 5'd31; i_MEM_pc = 32'h00400010;
    #1;
    total++; if ({o_MEM_alu_result, o_MEM_reg_write, o_MEM_mem_to_reg, o_MEM_r31_ctrl, o_MEM_selected_reg, o_MEM_pc} !== {32'h89ABCDEF, 3'b111, 5'd31, 32'h00400010})
      $display("FAIL passthrough got %h %b%b%b %h %h", o_MEM_alu_result, o_MEM_reg_write, o_MEM_mem_to_reg, o_MEM_r31_ctrl, o_MEM_selected_reg, o_MEM_pc); else passed++;
    i_MEM_alu_result = 32'h0; i_MEM_reg_write = 0; i_MEM_mem_to_reg = 0; i_MEM_r31_ctrl = 0;
  endtask
  task automatic test_async_reset;
    i_du_addr = 7'd4;
    @(negedge i_clock);
    set_acc(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h12345678);
    i_reset = 1'b1;
    #1;
    total++; if (o_du_data !== 32'h0) $display("FAIL async_clear got %h exp %h", o_du_data, 32'h0); else passed++;
    total++; if (o_MEM_misaligned !== 1'b0) $display("FAIL async_flag got %b exp 0", o_MEM_misaligned); else passed++;
    @(posedge i_clock); #1;
    total++; if (o_du_data !== 32'h0) $display("FAIL reset_store_lost got %h exp %h", o_du_data, 32'h0); else passed++;
    i_reset = 1'b0;
    set_acc(1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
  endtask
  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_enable();
    test_misaligned();
    test_rw_same();
    test_passthrough();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

MEM pipeline stage of the MIPS core: takes the EX/MEM register outputs, performs byte/halfword/word loads and stores against a local data memory, and produces the extended load data plus pass-through control that the MEM/WB register captures on the falling edge. It also exposes a read-only word port to the debug unit so memory contents can be dumped over UART while the core is halted.

## Interface
Parameters:
- NB_DATA, 32, data/word width
- NB_ADDR, 7, word-address width (memory depth 2^NB_ADDR words = 128)
- NB_REG, 5, register-index width
- NB_PC, 32, PC width

Ports:
- i_clock  in  1  single clock; memory writes and flag updates on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_enable  in  1  pipeline step enable from debug unit; 0 freezes all state
- i_MEM_mem_read  in  1  load instruction in MEM
- i_MEM_mem_write  in  1  store instruction in MEM
- i_MEM_bhw  in  2  access size: 00 byte, 01 halfword, 11 word, 10 reserved (treated as word)
- i_MEM_signed  in  1  1 sign-extend loads, 0 zero-extend
- i_MEM_alu_result  in  NB_DATA  byte address for load/store; also forwarded as ALU result
- i_MEM_write_data  in  NB_DATA  store data (rt), low bits used for byte/half
- i_MEM_reg_write, i_MEM_mem_to_reg, i_MEM_r31_ctrl  in  1 each  control pass-through
- i_MEM_selected_reg  in  NB_REG  destination register pass-through
- i_MEM_pc  in  NB_PC  PC pass-through
- i_du_addr  in  NB_ADDR  debug-unit word address
- o_MEM_mem_data  out  NB_DATA  extended load data (to MEM/WB mem_data)
- o_MEM_alu_result  out  NB_DATA  = i_MEM_alu_result
- o_MEM_reg_write, o_MEM_mem_to_reg, o_MEM_r31_ctrl, o_MEM_selected_reg, o_MEM_pc  out  as inputs  combinational pass-through
- o_MEM_misaligned  out  1  sticky misaligned-access flag
- o_du_data  out  NB_DATA  raw word at i_du_addr

## Operation
- Word index = i_MEM_alu_result[NB_ADDR+1:2]; higher address bits ignored (addresses wrap modulo 4·2^NB_ADDR bytes). Byte lane = addr[1:0].
- Alignment: byte always aligned; half misaligned if addr[0]=1; word misaligned if addr[1:0]≠00.
- Store (mem_write & i_enable & aligned): at rising edge write only addressed lanes. Byte: lane addr[1:0] ← write_data[7:0]. Half: lanes {addr[1],1}..{addr[1],0} ← write_data[15:0] (little-endian, addr[1]=0 → bits 15:0, =1 → bits 31:16). Word: all lanes. Other lanes unchanged.
- Load (combinational read): byte = word lane addr[1:0]; half = word[15:0] or [31:16] by addr[1]; word = full word. Extend to NB_DATA by i_MEM_signed. o_MEM_mem_data = 0 when mem_read=0 or access misaligned.
- Misaligned load or store with i_enable=1: store suppressed; o_MEM_misaligned set at rising edge, remains 1 until reset. mem_read and mem_write both 1: store performed, load data from pre-write contents.
- i_enable=0: no writes, flag holds; combinational outputs still follow inputs.
- Debug port: o_du_data = mem[i_du_addr], combinational, independent of i_enable.
- Reset: all memory words cleared to 0, o_MEM_misaligned = 0. Pass-through outputs and o_MEM_mem_data are combinational (follow inputs; 0 data for reads after reset), o_du_data = 0.

## Timing
- Load latency: 0 cycles; data valid before the falling edge at which MEM/WB captures.
- Store latency: contents updated at the rising edge; visible on load/debug ports immediately after that edge. Same-address debug read in the store cycle returns old value until the edge.
- Flag sets at the rising edge of the offending cycle.
- Reset asserted mid-store: write lost, memory cleared asynchronously; deassertion takes effect at next rising edge.

## Test plan
- Reset, then debug-read words 0, 64, 127 -> all 0x00000000, misaligned=0.
- Store word 0xDEADBEEF @0x10, load word @0x10 -> 0xDEADBEEF; debug addr 4 -> 0xDEADBEEF.
- Store byte 0x80 @0x21, load signed byte @0x21 -> 0xFFFFFF80, unsigned -> 0x00000080, word @0x20 -> 0x00008000.
- Store half 0x1234 @0x32 over word 0xAAAAAAAA @0x30 -> word 0x1234AAAA; signed half load @0x32 -> 0x00001234.
- Store word @0x41 -> memory unchanged, misaligned=1 next edge, stays 1 across later valid accesses until reset.
- i_enable=0 with store word 0x55 @0x08 -> word 2 stays 0; address 0x208 with enable -> aliases word 2 = 0x55.
